// File: rtl/bcd_score_counter.sv
// Multi-digit BCD up/down event counter with saturating or wrapping ceiling,
// a zero floor, and active-low 7-segment decode of every digit.
module bcd_score_counter #(
   parameter int DIGITS   = 2,
   parameter int MAX_VAL  = 99,
   parameter int WRAP     = 0,
   parameter int EDGE_DET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inc,
   input  logic                  dec,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   count,
   output logic [7*DIGITS-1:0]   hex,
   output logic                  at_max,
   output logic                  at_zero,
   output logic                  wrap
);

   localparam int W = 4 * DIGITS;

   function automatic logic [W-1:0] to_bcd(input int unsigned v);
      logic [W-1:0] r;
      int unsigned  t;
      r = '0;
      t = v;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(t % 32'd10);
         t = t / 32'd10;
      end
      return r;
   endfunction

   localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

   // Ripple a decimal carry from digit 0 upward.
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         carry;
      r     = v;
      carry = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (carry) begin
            if (r[4*k +: 4] == 4'd9) begin
               r[4*k +: 4] = 4'd0;
            end else begin
               r[4*k +: 4] = r[4*k +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end else begin
            carry = 1'b0;
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (borrow) begin
            if (r[4*k +: 4] == 4'd0) begin
               r[4*k +: 4] = 4'd9;
            end else begin
               r[4*k +: 4] = r[4*k +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end else begin
            borrow = 1'b0;
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   logic [W-1:0] count_q, count_d;
   logic         at_max_q, at_max_d;
   logic         at_zero_q, at_zero_d;
   logic         wrap_q, wrap_d;
   logic         inc_q, dec_q;
   logic         up, dn;

   always_comb begin
      up = (EDGE_DET != 0) ? (inc & ~inc_q) : inc;
      dn = (EDGE_DET != 0) ? (dec & ~dec_q) : dec;

      count_d = count_q;
      wrap_d  = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (up && dn) begin
         count_d = count_q;
      end else if (up) begin
         if (count_q == MAX_BCD) begin
            if (WRAP != 0) begin
               count_d = '0;
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q;
            end
         end else begin
            count_d = bcd_inc(count_q);
         end
      end else if (dn) begin
         if (count_q != '0) begin
            count_d = bcd_dec(count_q);
         end else begin
            count_d = count_q;
         end
      end else begin
         count_d = count_q;
      end
      at_max_d  = (count_d == MAX_BCD);
      at_zero_d = (count_d == '0);
   end

   // Edge history keeps sampling through reset so a held level never retriggers.
   always_ff @(posedge clk) begin
      inc_q <= inc;
      dec_q <= dec;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         at_max_q  <= 1'b0;
         at_zero_q <= 1'b1;
         wrap_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         at_max_q  <= at_max_d;
         at_zero_q <= at_zero_d;
         wrap_q    <= wrap_d;
      end
   end

   always_comb begin
      hex = '0;
      for (int k = 0; k < DIGITS; k++) begin
         hex[7*k +: 7] = seg7(count_q[4*k +: 4]);
      end
   end

   assign count   = count_q;
   assign at_max  = at_max_q;
   assign at_zero = at_zero_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Bench: four counter configurations driven by shared stimulus, each checked
// every cycle against an integer-valued model plus literal expectations.
module tb_bcd_score_counter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic inc = 1'b0;
   logic dec = 1'b0;
   logic clear = 1'b0;

   always #5 clk = ~clk;

   // a: sat 99 edge, b: wrap 99 edge, c: sat 99 level, d: 1 digit sat 7 edge
   logic [7:0]  count_a, count_b, count_c;
   logic [3:0]  count_d;
   logic [13:0] hex_a, hex_b, hex_c;
   logic [6:0]  hex_d;
   logic [3:0]  am, az, wr;

   bcd_score_counter #(.DIGITS(2), .MAX_VAL(99), .WRAP(0), .EDGE_DET(1)) u_a (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear),
      .count(count_a), .hex(hex_a), .at_max(am[0]), .at_zero(az[0]), .wrap(wr[0]));
   bcd_score_counter #(.DIGITS(2), .MAX_VAL(99), .WRAP(1), .EDGE_DET(1)) u_b (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear),
      .count(count_b), .hex(hex_b), .at_max(am[1]), .at_zero(az[1]), .wrap(wr[1]));
   bcd_score_counter #(.DIGITS(2), .MAX_VAL(99), .WRAP(0), .EDGE_DET(0)) u_c (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear),
      .count(count_c), .hex(hex_c), .at_max(am[2]), .at_zero(az[2]), .wrap(wr[2]));
   bcd_score_counter #(.DIGITS(1), .MAX_VAL(7), .WRAP(0), .EDGE_DET(1)) u_d (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear),
      .count(count_d), .hex(hex_d), .at_max(am[3]), .at_zero(az[3]), .wrap(wr[3]));

   int p_max  [4] = '{99, 99, 99, 7};
   int p_wrap [4] = '{0, 1, 0, 0};
   int p_edge [4] = '{1, 1, 0, 1};
   int p_dig  [4] = '{2, 2, 2, 1};
   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   int   m_val  [4];
   logic m_wrap [4];
   logic m_am   [4];
   logic m_az   [4];
   logic m_pinc = 1'b0;
   logic m_pdec = 1'b0;
   logic m_valid = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [23:0] exp_count(input int v, input int digs);
      logic [23:0] r = '0;
      int t = v;
      for (int k = 0; k < digs; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [41:0] exp_hex(input int v, input int digs);
      logic [41:0] r = '0;
      int t = v;
      for (int k = 0; k < digs; k++) begin
         r[7*k +: 7] = seg_tab[t % 10];
         t = t / 10;
      end
      return r;
   endfunction

   task automatic model_step();
      logic up, dn;
      for (int i = 0; i < 4; i++) begin
         up = (p_edge[i] != 0) ? (inc && !m_pinc) : inc;
         dn = (p_edge[i] != 0) ? (dec && !m_pdec) : dec;
         m_wrap[i] = 1'b0;
         if (reset) begin
            m_val[i] = 0;
         end else if (clear) begin
            m_val[i] = 0;
         end else if (up && dn) begin
            m_val[i] = m_val[i];
         end else if (up) begin
            if (m_val[i] < p_max[i]) m_val[i] = m_val[i] + 1;
            else if (p_wrap[i] != 0) begin
               m_val[i]  = 0;
               m_wrap[i] = 1'b1;
            end
         end else if (dn) begin
            if (m_val[i] > 0) m_val[i] = m_val[i] - 1;
         end
         m_am[i] = reset ? 1'b0 : (m_val[i] == p_max[i]);
         m_az[i] = (m_val[i] == 0);
      end
      m_pinc = inc;
      m_pdec = dec;
      if (reset) m_valid = 1'b1;
   endtask

   task automatic chk_inst(input int i, input logic [23:0] cnt, input logic [41:0] hx);
      chk($sformatf("count%0d", i), 64'(cnt), 64'(exp_count(m_val[i], p_dig[i])));
      chk($sformatf("hex%0d", i), 64'(hx), 64'(exp_hex(m_val[i], p_dig[i])));
      chk($sformatf("at_max%0d", i), 64'(am[i]), 64'(m_am[i]));
      chk($sformatf("at_zero%0d", i), 64'(az[i]), 64'(m_az[i]));
      chk($sformatf("wrap%0d", i), 64'(wr[i]), 64'(m_wrap[i]));
   endtask

   // Inputs change at negedge+1, so at negedge they are what the last posedge sampled.
   always @(negedge clk) begin
      model_step();
      if (m_valid) begin
         chk_inst(0, 24'(count_a), 42'(hex_a));
         chk_inst(1, 24'(count_b), 42'(hex_b));
         chk_inst(2, 24'(count_c), 42'(hex_c));
         chk_inst(3, 24'(count_d), 42'(hex_d));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_inc(input int n);
      for (int j = 0; j < n; j++) begin
         inc = 1'b1; tick();
         inc = 1'b0; tick();
      end
   endtask

   task automatic pulse_dec(input int n);
      for (int j = 0; j < n; j++) begin
         dec = 1'b1; tick();
         dec = 1'b0; tick();
      end
   endtask

   task automatic do_clear();
      clear = 1'b1; tick();
      clear = 1'b0; tick();
   endtask

   initial begin
      tick(); tick();
      chk("reset_count", 64'(count_a), 64'h00);
      chk("reset_at_zero", 64'(az[0]), 64'h1);
      chk("reset_at_max", 64'(am[0]), 64'h0);
      reset = 1'b0;

      pulse_inc(12);
      chk("t1_count", 64'(count_a), 64'h12);
      chk("t1_hex0", 64'(hex_a[6:0]), 64'h24);
      chk("t1_hex1", 64'(hex_a[13:7]), 64'h79);
      chk("t1_at_zero", 64'(az[0]), 64'h0);
      chk("t5_sat", 64'(count_d), 64'h7);
      chk("t5_at_max", 64'(am[3]), 64'h1);

      do_clear();
      inc = 1'b1;
      for (int j = 0; j < 10; j++) tick();
      inc = 1'b0; tick();
      chk("t2_edge", 64'(count_a), 64'h01);
      chk("t2_level", 64'(count_c), 64'h10);

      do_clear();
      pulse_inc(99);
      chk("t3_pre_sat", 64'(count_a), 64'h99);
      chk("t3_pre_wrap", 64'(count_b), 64'h99);
      inc = 1'b1; tick();
      chk("t3_wrap_count", 64'(count_b), 64'h00);
      chk("t3_wrap_pulse", 64'(wr[1]), 64'h1);
      chk("t3_sat_hold", 64'(count_a), 64'h99);
      chk("t3_sat_no_wrap", 64'(wr[0]), 64'h0);
      inc = 1'b0; tick();
      chk("t3_wrap_clear", 64'(wr[1]), 64'h0);
      inc = 1'b1; tick();
      chk("t3_after_wrap", 64'(count_b), 64'h01);
      chk("t3_sat_at_max", 64'(am[0]), 64'h1);
      inc = 1'b0; tick();

      do_clear();
      pulse_inc(10);
      dec = 1'b1; tick();
      chk("t4_borrow", 64'(count_a), 64'h09);
      dec = 1'b0; tick();
      do_clear();
      pulse_dec(3);
      chk("t4_floor", 64'(count_a), 64'h00);
      chk("t4_floor_zero", 64'(az[0]), 64'h1);

      do_clear();
      pulse_inc(5);
      inc = 1'b1; dec = 1'b1; tick();
      chk("t6_both", 64'(count_a), 64'h05);
      inc = 1'b0; dec = 1'b0; tick();
      inc = 1'b1; clear = 1'b1; tick();
      chk("t6_clear_inc", 64'(count_a), 64'h00);
      clear = 1'b0; tick();
      chk("t6_no_retrigger", 64'(count_a), 64'h00);
      inc = 1'b0; tick();

      do_clear();
      pulse_inc(45);
      chk("t6_pre_reset", 64'(count_a), 64'h45);
      reset = 1'b1; tick();
      chk("t6_reset", 64'(count_a), 64'h00);
      chk("t6_reset_zero", 64'(az[0]), 64'h1);
      reset = 1'b0; tick();

      for (int j = 0; j < 1500; j++) begin
         inc   = 1'($urandom_range(0, 1));
         dec   = ($urandom_range(0, 7) == 0);
         clear = ($urandom_range(0, 255) == 0);
         reset = ($urandom_range(0, 511) == 0);
         tick();
      end
      for (int j = 0; j < 1500; j++) begin
         inc   = 1'($urandom_range(0, 1));
         dec   = 1'($urandom_range(0, 1));
         clear = ($urandom_range(0, 63) == 0);
         reset = ($urandom_range(0, 127) == 0);
         tick();
      end
      inc = 1'b0; dec = 1'b0; clear = 1'b0; reset = 1'b0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
